// File: rtl/mp_seq_ctrl.sv
// mp_seq_ctrl: IDLE/EXEC/DONE sequencer and radix-2 shift-add datapath for mp.
// Define MP_SIGNED_EN for two's-complement operands via radix-2 Booth recoding.
module mp_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               interrupt,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [1:0]         state,
    output logic [2*WIDTH-1:0] result,
    output logic               op_done,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10,
        S_ILL  = 2'b11
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               start_q;
    logic               start_ok;
    logic               load;
    logic               step;
    logic               last;
    logic               clr_res;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] mcand_ext;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier;
    logic               b_prev;

    // A start is a rising edge of op_start, so a level held through EXEC
    // cannot re-launch the unit from DONE.
    assign start_ok = op_start && !start_q;
    assign last     = (cnt == CW'(WIDTH - 1));

`ifdef MP_SIGNED_EN
    assign mcand_ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};

    always_comb begin
        acc_step = acc;
        case ({mplier[0], b_prev})
            2'b01:   acc_step = acc + mcand;
            2'b10:   acc_step = acc - mcand;
            default: acc_step = acc;
        endcase
    end
`else
    assign mcand_ext = {{WIDTH{1'b0}}, multiplicand};

    always_comb begin
        acc_step = acc;
        if (mplier[0])
            acc_step = acc + mcand;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        clr_res = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!interrupt && start_ok) begin
                    state_d = S_EXEC;
                    load    = 1'b1;
                end
            end
            S_EXEC: begin
                if (interrupt) begin
                    state_d = S_IDLE;
                    clr_res = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (interrupt || op_clear) begin
                    state_d = S_IDLE;
                    clr_res = 1'b1;
                end else if (start_ok) begin
                    state_d = S_EXEC;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                clr_res = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            b_prev  <= 1'b0;
            acc     <= '0;
            result  <= '0;
        end else begin
            start_q <= op_start;
            if (load) begin
                mcand  <= mcand_ext;
                mplier <= multiplier;
                b_prev <= 1'b0;
                acc    <= '0;
                cnt    <= '0;
            end else if (step) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                b_prev <= mplier[0];
                cnt    <= cnt + 1'b1;
                if (last)
                    result <= acc_step;
            end
            if (clr_res) begin
                result <= '0;
                acc    <= '0;
                cnt    <= '0;
            end
        end
    end

    assign state   = (state_q == S_ILL) ? S_IDLE : state_q;
    assign op_done = (state_q == S_DONE);
    assign busy    = (state_q == S_EXEC);

endmodule

// File: tb/tb_mp_seq_ctrl.sv
// tb_mp_seq_ctrl: directed vectors, expected products queued to a done-edge monitor.
// Build with MP_SIGNED_EN to exercise the Booth variant.
module tb_mp_seq_ctrl;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           op_start;
    logic           op_clear;
    logic           interrupt;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic [1:0]     state;
    logic [2*W-1:0] result;
    logic           op_done;
    logic           busy;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [2*W-1:0] exp_q[$];
    logic           done_seen = 1'b0;

    mp_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .interrupt    (interrupt),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .state        (state),
        .result       (result),
        .op_done      (op_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising op_done must match the oldest queued product.
    always @(negedge clk) begin
        if (op_done === 1'b1 && !done_seen) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got result %h expected no done",
                         result);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    n_fail++;
                    $display("FAIL product: got %h expected %h", result, e);
                end
            end
        end
        done_seen = (op_done === 1'b1);
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp,
                          input logic [2*W-1:0] old_res);
        int n;
        int hold_bad;
        exp_q.push_back(exp);
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        chk("start_state", 64'(state), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        n = 0;
        hold_bad = 0;
        while (!op_done && n < 64) begin
            if (result !== old_res)
                hold_bad++;
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'd32);
        chk("result_hold", 64'(hold_bad), 64'd0);
        chk("done_state", 64'(state), 64'd2);
        tick();
    endtask

    initial begin
        int n;
        int rises;
        int first_done;
        logic prev;

        reset        = 1'b1;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        interrupt    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_done", 64'(op_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        run_op(32'd7, 32'd6, 64'd42, 64'd0);
        run_op(32'd3, 32'd5, 64'd15, 64'd42);
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        chk("clear_state", 64'(state), 64'd0);
        chk("clear_result", result, 64'd0);

`ifdef MP_SIGNED_EN
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 64'd0);
        run_op(32'hFFFFFFFD, 32'd5, 64'hFFFFFFFFFFFFFFF1, 64'h1);
        run_op(32'h80000000, 32'd2, 64'hFFFFFFFF00000000,
               64'hFFFFFFFFFFFFFFF1);
`else
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 64'd0);
        run_op(32'h80000000, 32'd2, 64'h0000000100000000,
               64'hFFFFFFFE00000001);
`endif
        run_op(32'd0, 32'd12345, 64'd0, result);

        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        chk("int_done_state", 64'(state), 64'd0);
        chk("int_done_result", result, 64'd0);

        multiplicand = 32'd9;
        multiplier   = 32'd9;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        for (int i = 0; i < 10; i++)
            tick();
        chk("pre_int_busy", 64'(busy), 64'd1);
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        chk("int_exec_state", 64'(state), 64'd0);
        chk("int_exec_result", result, 64'd0);
        chk("int_exec_done", 64'(op_done), 64'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (op_done || busy)
                rises++;
            tick();
        end
        chk("int_no_activity", 64'(rises), 64'd0);

        interrupt = 1'b1;
        op_start  = 1'b1;
        tick();
        chk("int_start_idle", 64'(state), 64'd0);
        interrupt = 1'b0;
        op_start  = 1'b0;
        tick();
        chk("int_start_idle2", 64'(state), 64'd0);

        exp_q.push_back(64'd20);
        multiplicand = 32'd4;
        multiplier   = 32'd5;
        op_start = 1'b1;
        rises = 0;
        first_done = -1;
        prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (op_done && !prev) begin
                rises++;
                if (first_done < 0)
                    first_done = i - 1;
            end
            prev = op_done;
        end
        op_start = 1'b0;
        chk("held_ops", 64'(rises), 64'd1);
        chk("held_done_cycle", 64'(first_done), 64'd32);
        chk("held_state", 64'(state), 64'd2);
        tick();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;

        multiplicand = 32'd11;
        multiplier   = 32'd13;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        for (int i = 0; i < 5; i++)
            tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 64'(state), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_done", 64'(op_done), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || op_done)
                n++;
            tick();
        end
        chk("mid_rst_quiet", 64'(n), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
